i2c_arbiter: RTL and testbench
==============================

# i2c_arbiter

Shares one I2C byte-level master (the engine behind the `hd44780` LCD driver) between `NREQ` requesters. Round-robin arbitration. Each granted requester streams one write transaction (START, bytes, STOP); the block sequences the master's `cmd`/`busy` handshake on the requester's behalf. Sits between client blocks (LCD driver, sensor pollers) and the single `i2c` master instance.

## Interface
- `NREQ`, 2: number of requesters, 2..8.
- `WDOG_CYCLES`, 100000: watchdog limit in `clk` cycles for any single master wait (only with `I2C_ARB_WDOG_EN`).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  NREQ  requester i wants the bus; held high for the whole transaction.
- `wvalid`  in  NREQ  byte available from requester i.
- `wdata`  in  NREQ*8  byte of requester i at bits [8i+7:8i]; first byte is address+R/W.
- `wlast`  in  NREQ  current byte is the final one of the transaction.
- `wready`  out  NREQ  arbiter accepts requester i's byte this cycle.
- `gnt`  out  NREQ  one-hot registered grant.
- `done`  out  NREQ  1-cycle pulse: transaction of i finished with all ACKs.
- `err`  out  NREQ  1-cycle pulse: transaction of i ended by NACK, abort or watchdog.
- `m_cmd`  out  `i2c_cmd_t`  command to master.
- `m_data`  out  8  byte to master, valid with `CMD_WRITE`.
- `m_busy`  in  1  master busy.
- `m_error`  in  1  master saw NACK on the last byte; valid when `m_busy` falls.
- `wdog_trip`  out  1  sticky watchdog flag, cleared only by reset.

## Operation
- States: `IDLE`, `GRANT`, `START`, `START_W`, `FETCH`, `WRITE`, `WRITE_W`, `STOP`, `STOP_W`, `FIN`.
- `IDLE`: if any `req`, choose winner round-robin from pointer `ptr` (lowest index at or above `ptr`, wrapping); register `gnt`; go `GRANT`.
- `GRANT` -> `START`.
- Master handshake (all of `START`, `WRITE`, `STOP`): drive command until `m_busy`=1, then `m_cmd`=`CMD_IDLE` and go to matching `_W`; in `_W` wait for `m_busy`=0.
- `START_W` done -> `FETCH`.
- `FETCH`: `wready[g]`=1. On `wvalid[g]`: latch `wdata`, latch `wlast` into `last_q`, go `WRITE`. If `req[g]`=0: abort, set `err_q`, go `STOP`.
- `WRITE_W` done:
  - `m_error`=1: set `err_q`, go `STOP`.
  - else if `last_q`: go `STOP`.
  - else go `FETCH`.
- `STOP_W` done -> `FIN`.
- `FIN`: pulse `err[g]` if `err_q`, else `done[g]`. Set `ptr`=g+1 mod `NREQ`. Clear `gnt`, go `IDLE`.
- Grant is not revoked by new requests; no preemption.
- `req` dropped outside `FETCH`: ignored until the next `FETCH`.

## Timing
- Reset values:
  - `gnt`, `wready`, `done`, `err`, `wdog_trip`: 0.
  - `m_cmd`=`CMD_IDLE`, `m_data`=0, `ptr`=0, state `IDLE`.
- Reset mid-transaction returns to `IDLE` on the next edge. No STOP is issued; the master is reset by the same `rst_n`.
- `req` high in `IDLE` -> `gnt` high 1 cycle later; `m_cmd`=`CMD_START` 2 cycles after `req`.
- `wready` is combinational from state and is high only in `FETCH`. Byte transfer occurs on `wvalid`&`wready`, at most one byte per `FETCH` visit.
- `m_data` is registered; it is stable from entry to `WRITE` until `WRITE_W` exits.
- `done`/`err` are high for exactly one cycle, in the cycle state is `FIN`. `gnt` falls the next cycle.
- Earliest regrant is 2 cycles after `FIN`. Requester at `ptr` wins ties.

## Configuration
- `I2C_ARB_WDOG_EN` defined:
  - A counter runs in every `_W` state and reloads on state change.
  - On reaching `WDOG_CYCLES`: `m_cmd`=`CMD_IDLE`, `wdog_trip`=1, `err[g]` pulses, `ptr` advances, state goes to `IDLE` without STOP.
- Undefined: no counter is built, `_W` states wait indefinitely, `wdog_trip` is tied 0.

## Structure
- Package `i2c_pkg`:
  - `i2c_cmd_t` (`CMD_IDLE`, `CMD_START`, `CMD_WRITE`, `CMD_STOP`), shared with the master.
  - `arb_state_t`.
  - Constant `I2C_ARB_MAX_REQ`=8.
- Sub-module `rr_arbiter`: combinational one-hot winner from `req` and `ptr`. The FSM stays in `i2c_arbiter`.

## Test plan
- Single requester 0 sends 0x4E,0x08,0x0C (last) with the master model ACKing. Required: master sees START, 3 WRITEs with matching `m_data`, STOP; `done[0]` pulses once; `err`=0.
- Both `req` high from reset, 2 bytes each. Required: `gnt`=01 first, then 10; `ptr` alternates; no `m_cmd` overlap between transactions.
- Master asserts `m_error` after byte 1 of 3. Required: no further WRITE; STOP issued; `err[0]` pulses; `done[0]` stays 0.
- Requester 1 drops `req` in `FETCH` after 1 byte. Required: STOP, `err[1]` pulse, `gnt` clears, requester 0 served next.
- With `I2C_ARB_WDOG_EN`, `WDOG_CYCLES`=50, `m_busy` held high after START. Required: `err[0]` 50 cycles after `START_W` entry, `wdog_trip`=1, state `IDLE`.
- `rst_n`=0 during `WRITE_W`. Required: next cycle all outputs at reset values, `m_cmd`=`CMD_IDLE`.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: types and constants shared by the I2C byte master, the
// requester arbiter (i2c_arbiter) and its round-robin helper.
//   i2c_cmd_t    command encoding driven towards the byte master
//   arb_state_t  arbiter FSM state, also exported on a debug port
//   rr_next      wrap-around increment used for the round-robin pointer
package i2c_pkg;

  localparam int I2C_ARB_MAX_REQ = 8;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_START = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_STOP  = 2'd3
  } i2c_cmd_t;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    GRANT   = 4'd1,
    START   = 4'd2,
    START_W = 4'd3,
    FETCH   = 4'd4,
    WRITE   = 4'd5,
    WRITE_W = 4'd6,
    STOP    = 4'd7,
    STOP_W  = 4'd8,
    FIN     = 4'd9
  } arb_state_t;

  // Index following idx among n requesters, wrapping to 0.
  function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
    if (int'(idx) + 1 >= n) return 3'd0;
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req      requests, one bit per requester
//   ptr      index with highest priority this round
//   win      one-hot winner (all zero when nobody requests)
//   win_idx  binary index of the winner
//   any      at least one request present
// The winner is the lowest requesting index at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   win_idx,
  output logic            any
);

  // One extra bit so ptr + offset cannot overflow before wrapping.
  localparam logic [PW:0] N_W = (PW + 1)'(NREQ);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int off = 0; off < NREQ; off++) begin
      sum = {1'b0, ptr} + (PW + 1)'(off);
      if (sum >= N_W) sum = sum - N_W;
      idx = sum[PW-1:0];
      if (!any && req[idx]) begin
        any      = 1'b1;
        win[idx] = 1'b1;
        win_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one I2C byte master between NREQ requesters.
// A granted requester streams one write transaction (START, bytes, STOP);
// the arbiter runs the master's cmd/busy handshake on its behalf.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   req/wvalid/wdata/wlast  per-requester request and byte stream
//   wready             byte accept (high only in FETCH, for the granted one)
//   gnt                registered one-hot grant
//   done / err         one-cycle completion pulses (ok / NACK-abort-watchdog)
//   m_cmd, m_data      command and byte towards the master
//   m_busy, m_error    master status; m_error is valid when m_busy falls
//   wdog_trip          sticky watchdog flag
//   state              current FSM state (debug)
//
// Handshakes: a byte moves from requester g when wvalid[g] & wready[g] are
// both high at a rising edge. Towards the master, a command is held on
// m_cmd until m_busy is seen high; m_cmd then returns to CMD_IDLE and the
// FSM waits in the matching _W state for m_busy to fall.
//
// Build option: define I2C_ARB_WDOG_EN to add a watchdog that abandons any
// master wait lasting WDOG_CYCLES cycles. Without it wdog_trip is tied low.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int WDOG_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   wvalid,
  input  logic [NREQ*8-1:0] wdata,
  input  logic [NREQ-1:0]   wlast,
  output logic [NREQ-1:0]   wready,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output i2c_cmd_t          m_cmd,
  output logic [7:0]        m_data,
  input  logic              m_busy,
  input  logic              m_error,
  output logic              wdog_trip,
  output arb_state_t        state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            last_q, last_d;
  logic            err_q, err_d;
  logic [7:0]      data_q, data_d;

  logic [NREQ-1:0] win;
  logic [PW-1:0]   win_idx;
  logic            any_req;
  logic [PW-1:0]   ptr_next;
  logic            wd_hit;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx),
    .any     (any_req)
  );

  assign ptr_next = PW'(rr_next(3'(gidx_q), NREQ));

`ifdef I2C_ARB_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] wd_cnt;
  logic          in_wait;
  logic          wdog_q;

  assign in_wait = (state_q == START_W) || (state_q == WRITE_W) || (state_q == STOP_W);
  // wd_cnt is 0 in the first cycle of a wait, so the hit lands WDOG_CYCLES
  // cycles after entering the _W state.
  assign wd_hit  = in_wait && (wd_cnt == CW'(WDOG_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      wdog_q <= 1'b0;
    end else begin
      if (!in_wait || (state_d != state_q)) wd_cnt <= '0;
      else                                  wd_cnt <= wd_cnt + 1'b1;
      if (wd_hit) wdog_q <= 1'b1;
    end
  end

  assign wdog_trip = wdog_q;
`else
  assign wd_hit    = 1'b0;
  // The limit only matters when the watchdog is built.
  assign wdog_trip = 1'b0 & (|WDOG_CYCLES);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    err_d   = err_q;
    data_d  = data_q;
    m_cmd   = CMD_IDLE;
    wready  = '0;
    done    = '0;
    err     = '0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = win;
          gidx_d  = win_idx;
          err_d   = 1'b0;
          last_d  = 1'b0;
          state_d = GRANT;
        end
      end
      GRANT: state_d = START;
      START: begin
        m_cmd = CMD_START;
        if (m_busy) state_d = START_W;
      end
      START_W: if (!m_busy) state_d = FETCH;
      FETCH: begin
        // gnt_q is the one-hot of the granted requester.
        wready = gnt_q;
        if (wvalid[gidx_q]) begin
          data_d  = wdata[{gidx_q, 3'b000} +: 8];
          last_d  = wlast[gidx_q];
          state_d = WRITE;
        end else if (!req[gidx_q]) begin
          err_d   = 1'b1;
          state_d = STOP;
        end
      end
      WRITE: begin
        m_cmd = CMD_WRITE;
        if (m_busy) state_d = WRITE_W;
      end
      WRITE_W: begin
        if (!m_busy) begin
          if (m_error) begin
            err_d   = 1'b1;
            state_d = STOP;
          end else if (last_q) begin
            state_d = STOP;
          end else begin
            state_d = FETCH;
          end
        end
      end
      STOP: begin
        m_cmd = CMD_STOP;
        if (m_busy) state_d = STOP_W;
      end
      STOP_W: if (!m_busy) state_d = FIN;
      FIN: begin
        if (err_q) err  = gnt_q;
        else       done = gnt_q;
        ptr_d   = ptr_next;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Watchdog abandons the transaction without a STOP.
    if (wd_hit) begin
      m_cmd   = CMD_IDLE;
      err     = gnt_q;
      done    = '0;
      ptr_d   = ptr_next;
      gnt_d   = '0;
      state_d = IDLE;
    end
  end

  assign gnt    = gnt_q;
  assign m_data = data_q;
  assign state  = state_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
module tb_i2c_arbiter;
  import i2c_pkg::*;

  localparam int WDOG = 50;
  localparam int LAT  = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req, wvalid, wlast, wready, gnt, done, err;
  logic [15:0] wdata;
  i2c_cmd_t    m_cmd;
  logic [7:0]  m_data;
  logic        m_busy, m_error, wdog_trip;
  arb_state_t  state;

  i2c_arbiter #(.NREQ(2), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wvalid(wvalid), .wdata(wdata),
    .wlast(wlast), .wready(wready), .gnt(gnt), .done(done), .err(err),
    .m_cmd(m_cmd), .m_data(m_data), .m_busy(m_busy), .m_error(m_error),
    .wdog_trip(wdog_trip), .state(state)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // scoreboard: expected master commands {cmd, data} and completion events {is_err, idx}
  logic [9:0] exp_q[$];
  logic [1:0] exp_ev[$];

  // requester models
  logic [7:0] bytes [2][4];
  int   len [2];
  int   pos [2];
  int   drop_at [2];
  logic req_on [2];
  logic pend [2];

  // master model
  int       busy_cnt;
  logic     hold_busy;
  int       nack_at;
  int       wr_cnt;
  logic     nack_now;
  i2c_cmd_t cur_cmd;
  logic [7:0] data_seen;
  logic [9:0] got, expv;
  logic [1:0] got_ev, exp_e;

  initial begin
    req = '0; wvalid = '0; wlast = '0; wdata = '0;
    m_busy = 1'b0; m_error = 1'b0;
    busy_cnt = 0; hold_busy = 1'b0; nack_at = -1; wr_cnt = 0; nack_now = 1'b0;
    cur_cmd = CMD_IDLE; data_seen = 8'h00;
    for (int i = 0; i < 2; i++) begin
      len[i] = 0; pos[i] = 0; drop_at[i] = -1; req_on[i] = 1'b0; pend[i] = 1'b0;
    end
  end

  // All bench-side models act on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      busy_cnt = 0; m_busy = 1'b0; m_error = 1'b0;
      req = '0; wvalid = '0; wlast = '0; wdata = '0;
      for (int i = 0; i < 2; i++) pend[i] = 1'b0;
    end else begin
      // completion monitor
      for (int i = 0; i < 2; i++) begin
        if (done[i] || err[i]) begin
          got_ev = {err[i], (i == 1)};
          total++;
          if (exp_ev.size() == 0) begin
            bad++;
            $display("FAIL event: unexpected done/err=%b req=%0d, none expected", got_ev, i);
          end else begin
            exp_e = exp_ev.pop_front();
            if (got_ev !== exp_e) begin
              bad++;
              $display("FAIL event: got {err,idx}=%b expected %b", got_ev, exp_e);
            end
          end
          req_on[i] = 1'b0;
        end
      end
      // master model
      if (busy_cnt > 0) begin
        if (!hold_busy) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            m_busy = 1'b0;
            m_error = nack_now;
            if (cur_cmd == CMD_WRITE) begin
              total++;
              if (m_data !== data_seen) begin
                bad++;
                $display("FAIL m_data_stable: got %h expected %h", m_data, data_seen);
              end
            end
          end
        end
      end else if (m_cmd != CMD_IDLE) begin
        got = {m_cmd, (m_cmd == CMD_WRITE) ? m_data : 8'h00};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL master_cmd: got %h, none expected", got);
        end else begin
          expv = exp_q.pop_front();
          if (got !== expv) begin
            bad++;
            $display("FAIL master_cmd: got %h expected %h", got, expv);
          end
        end
        if (m_cmd == CMD_WRITE) begin
          nack_now = (wr_cnt == nack_at);
          wr_cnt++;
        end else begin
          nack_now = 1'b0;
        end
        cur_cmd = m_cmd; data_seen = m_data;
        m_busy = 1'b1; m_error = 1'b0; busy_cnt = LAT;
      end
      // requester drivers
      for (int i = 0; i < 2; i++) begin
        if (pend[i]) pos[i]++;
        if (drop_at[i] >= 0 && pos[i] >= drop_at[i]) req_on[i] = 1'b0;
        req[i] = req_on[i];
        wvalid[i] = req_on[i] && (pos[i] < len[i]);
        wdata[i*8 +: 8] = (pos[i] < len[i]) ? bytes[i][pos[i]] : 8'h00;
        wlast[i] = (pos[i] == len[i] - 1);
        pend[i] = wvalid[i] && wready[i];
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete(); exp_ev.delete();
    hold_busy = 1'b0; nack_at = -1; wr_cnt = 0; nack_now = 1'b0;
    for (int i = 0; i < 2; i++) begin
      len[i] = 0; pos[i] = 0; drop_at[i] = -1; req_on[i] = 1'b0; pend[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Call between a rising edge and the next falling edge.
  task automatic load(input int i, input int n, input logic [31:0] data, input int drop);
    for (int k = 0; k < 4; k++) bytes[i][k] = data[8*k +: 8];
    len[i] = n; pos[i] = 0; drop_at[i] = drop; pend[i] = 1'b0; req_on[i] = 1'b1;
  endtask

  task automatic push_tx(input int i, input int nwr);
    exp_q.push_back({CMD_START, 8'h00});
    for (int k = 0; k < nwr; k++) exp_q.push_back({CMD_WRITE, bytes[i][k]});
    exp_q.push_back({CMD_STOP, 8'h00});
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && exp_ev.size() == 0 && state == IDLE && busy_cnt == 0) && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL %s_drain: cmds left=%0d events left=%0d state=%0d", name, exp_q.size(), exp_ev.size(), state);
    end
  endtask

  task automatic expect_next_grant(input logic [1:0] g, input string name);
    int n;
    n = 0;
    while (gnt !== 2'b00 && n < 2000) begin @(negedge clk); #1; n++; end
    while (gnt === 2'b00 && n < 2000) begin @(negedge clk); #1; n++; end
    total++;
    if (gnt !== g) begin
      bad++;
      $display("FAIL %s_grant: got %b expected %b", name, gnt, g);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); #1;
    total += 8;
    if (gnt !== 2'b00)      begin bad++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    if (wready !== 2'b00)   begin bad++; $display("FAIL reset_wready: got %b expected 00", wready); end
    if (done !== 2'b00)     begin bad++; $display("FAIL reset_done: got %b expected 00", done); end
    if (err !== 2'b00)      begin bad++; $display("FAIL reset_err: got %b expected 00", err); end
    if (wdog_trip !== 1'b0) begin bad++; $display("FAIL reset_wdog: got %b expected 0", wdog_trip); end
    if (m_cmd !== CMD_IDLE) begin bad++; $display("FAIL reset_cmd: got %0d expected 0", m_cmd); end
    if (m_data !== 8'h00)   begin bad++; $display("FAIL reset_data: got %h expected 00", m_data); end
    if (state !== IDLE)     begin bad++; $display("FAIL reset_state: got %0d expected 0", state); end
  endtask

  task automatic test_single();
    do_reset();
    @(posedge clk); #1;
    load(0, 3, 32'h000C084E, -1);
    push_tx(0, 3);
    exp_ev.push_back(2'b00);
    @(negedge clk); #1;  // req now high, state IDLE
    @(negedge clk); #1;
    total++;
    if (gnt !== 2'b01) begin bad++; $display("FAIL single_gnt_latency: got %b expected 01", gnt); end
    @(negedge clk); #1;
    total++;
    if (m_cmd !== CMD_START) begin bad++; $display("FAIL single_start_latency: got %0d expected %0d", m_cmd, CMD_START); end
    wait_quiet("single");
  endtask

  task automatic test_two_req();
    do_reset();
    @(posedge clk); #1;
    load(0, 2, 32'h0000_1122, -1);
    load(1, 2, 32'h0000_3344, -1);
    push_tx(0, 2);
    push_tx(1, 2);
    exp_ev.push_back(2'b00);
    exp_ev.push_back(2'b01);
    @(negedge clk); #1;
    @(negedge clk); #1;
    total++;
    if (gnt !== 2'b01) begin bad++; $display("FAIL two_first_gnt: got %b expected 01", gnt); end
    expect_next_grant(2'b10, "two_second");
    wait_quiet("two");
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(posedge clk); #1;
    load(0, 1, 32'h0000_00A5, -1);
    push_tx(0, 1);
    exp_ev.push_back(2'b00);
    wait_quiet("b2b_warm");
    // pointer now favours requester 1
    @(posedge clk); #1;
    load(0, 1, 32'h0000_005A, -1);
    load(1, 1, 32'h0000_00C3, -1);
    push_tx(1, 1);
    push_tx(0, 1);
    exp_ev.push_back(2'b01);
    exp_ev.push_back(2'b00);
    expect_next_grant(2'b10, "b2b_first");
    expect_next_grant(2'b01, "b2b_second");
    wait_quiet("b2b");
  endtask

  task automatic test_nack();
    do_reset();
    @(posedge clk); #1;
    nack_at = 0;
    load(0, 3, 32'h0033_2211, -1);
    push_tx(0, 1);
    exp_ev.push_back(2'b10);
    wait_quiet("nack");
  endtask

  task automatic test_drop();
    do_reset();
    @(posedge clk); #1;
    load(1, 3, 32'h0077_6655, 1);
    push_tx(1, 1);
    exp_ev.push_back(2'b11);
    expect_next_grant(2'b10, "drop_first");
    @(posedge clk); #1;
    load(0, 2, 32'h0000_9988, -1);
    push_tx(0, 2);
    exp_ev.push_back(2'b00);
    expect_next_grant(2'b01, "drop_next");
    wait_quiet("drop");
  endtask

  task automatic test_watchdog();
    int n, c0, c1;
    do_reset();
    @(posedge clk); #1;
    hold_busy = 1'b1;
    load(0, 1, 32'h0000_0042, -1);
    exp_q.push_back({CMD_START, 8'h00});
    n = 0;
    while (state !== START_W && n < 100) begin @(negedge clk); #1; n++; end
    c0 = cyc;
`ifdef I2C_ARB_WDOG_EN
    exp_ev.push_back(2'b10);
    n = 0;
    while (err[0] !== 1'b1 && n < 300) begin @(negedge clk); #1; n++; end
    c1 = cyc;
    total++;
    if (c1 - c0 !== WDOG) begin bad++; $display("FAIL wdog_latency: got %0d cycles expected %0d", c1 - c0, WDOG); end
    @(negedge clk); #1;
    total += 3;
    if (state !== IDLE)     begin bad++; $display("FAIL wdog_state: got %0d expected 0", state); end
    if (wdog_trip !== 1'b1) begin bad++; $display("FAIL wdog_trip: got %b expected 1", wdog_trip); end
    if (exp_ev.size() != 0) begin bad++; $display("FAIL wdog_err_pulse: %0d events missing", exp_ev.size()); end
`else
    repeat (3 * WDOG) @(negedge clk);
    #1;
    c1 = cyc;
    total += 2;
    if (state !== START_W || c1 == c0) begin bad++; $display("FAIL nowdog_state: got %0d expected %0d", state, START_W); end
    if (wdog_trip !== 1'b0) begin bad++; $display("FAIL nowdog_trip: got %b expected 0", wdog_trip); end
`endif
    do_reset();
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    @(posedge clk); #1;
    load(0, 3, 32'h0003_0201, -1);
    push_tx(0, 3);
    n = 0;
    while (state !== WRITE_W && n < 200) begin @(negedge clk); #1; n++; end
    total++;
    if (state !== WRITE_W) begin bad++; $display("FAIL rstmid_reach: got %0d expected %0d", state, WRITE_W); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    total += 6;
    if (state !== IDLE)     begin bad++; $display("FAIL rstmid_state: got %0d expected 0", state); end
    if (m_cmd !== CMD_IDLE) begin bad++; $display("FAIL rstmid_cmd: got %0d expected 0", m_cmd); end
    if (gnt !== 2'b00)      begin bad++; $display("FAIL rstmid_gnt: got %b expected 00", gnt); end
    if (m_data !== 8'h00)   begin bad++; $display("FAIL rstmid_data: got %h expected 00", m_data); end
    if (wready !== 2'b00 || done !== 2'b00 || err !== 2'b00) begin
      bad++; $display("FAIL rstmid_pulses: wready=%b done=%b err=%b expected 00", wready, done, err);
    end
    if (wdog_trip !== 1'b0) begin bad++; $display("FAIL rstmid_wdog: got %b expected 0", wdog_trip); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_req();
    test_back_to_back();
    test_nack();
    test_drop();
    test_watchdog();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
